// File: rtl/fft_cfg_pkg.sv
// Shared configuration types and the point-size to stage-control mapping
// for the runtime-configurable SDF FFT input stage.
package fft_cfg_pkg;

  localparam int LOG2_NMIN = 5;
  localparam int LOG2_NMAX = 10;
  localparam int NUM_STAGE = (LOG2_NMAX + 1) / 2;
  localparam int NUM_ENTRY = (LOG2_NMAX - LOG2_NMIN) / 2 + 1;
  localparam int ENTRY_W   = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;
  localparam int LML_W     = NUM_STAGE * 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    RECONFIG = 2'd2
  } fe_state_t;

  // Everything the pipeline needs to know about one point size.
  typedef struct packed {
    logic [ENTRY_W-1:0]   entry;
    logic [LOG2_NMAX-1:0] cnt_max;
    logic [2:0]           tw_addr_shift;
    logic [LML_W-1:0]     logn_minus_logm;
  } mode_cfg_t;

  function automatic logic log2n_legal(input logic [3:0] l);
    return (int'(l) >= LOG2_NMIN) && (int'(l) <= LOG2_NMAX);
  endfunction

  // Entry stage e skips the first e radix-2^2 stages. Stages from the entry
  // onward see log2N-log2M growing by 2 per stage. When LOG2_NMAX-L is odd the
  // final stage degenerates to a radix-2 butterfly whose field is forced to 0.
  function automatic mode_cfg_t mode_to_cfg(input logic [3:0] l);
    mode_cfg_t c;
    int diff;
    int e;
    diff = LOG2_NMAX - int'(l);
    e    = diff / 2;
    c.entry           = ENTRY_W'(e);
    c.cnt_max         = LOG2_NMAX'((32'd1 << l) - 32'd1);
    c.tw_addr_shift   = 3'(diff);
    c.logn_minus_logm = '0;
    for (int k = 0; k < NUM_STAGE; k++) begin
      if ((k >= e) && !(diff[0] && (k == NUM_STAGE - 1))) begin
        c.logn_minus_logm[k*4 +: 4] = 4'(2 * (k - e));
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/fft_mode_decode.sv
// Combinational point-size decoder: log2(N) -> per-size control record.
// The caller registers the result.
module fft_mode_decode
  import fft_cfg_pkg::*;
(
  input  logic [3:0] log2n,
  output mode_cfg_t  cfg,
  output logic       legal
);

  // Table lookup of entry stage, counter limit, twiddle shift and stage fields.
  always_comb begin
    cfg   = mode_to_cfg(log2n);
    legal = log2n_legal(log2n);
  end

endmodule

// File: rtl/fft_input_frontend.sv
// Input stage of the runtime-configurable SDF FFT: routes each accepted
// sample to the entry stage for the active point size, tracks frame
// position, and applies requested size changes only between frames.
module fft_input_frontend #(
  parameter int WIDTH         = 16,
  parameter int LOG2_NMIN     = 5,
  parameter int LOG2_NMAX     = 10,
  parameter int DEFAULT_LOG2N = 8
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [3:0]                                    cfg_log2n,
  input  logic                                          cfg_valid,
  input  logic                                          in_valid,
  input  logic [WIDTH-1:0]                              in_re,
  input  logic [WIDTH-1:0]                              in_im,
  output logic                                          in_ready,
  output logic [(LOG2_NMAX-LOG2_NMIN)/2:0]              out_en,
  output logic [((LOG2_NMAX-LOG2_NMIN)/2+1)*WIDTH-1:0]  out_re,
  output logic [((LOG2_NMAX-LOG2_NMIN)/2+1)*WIDTH-1:0]  out_im,
  output logic                                          out_sop,
  output logic                                          out_eop,
  output logic [LOG2_NMAX-1:0]                          out_idx,
  output logic [LOG2_NMAX-1:0]                          cnt_max,
  output logic [3:0]                                    log2n_do,
  output logic [2:0]                                    tw_addr_shift,
  output logic [((LOG2_NMAX+1)/2)*4-1:0]                logn_minus_logm,
  output logic                                          busy,
  output logic                                          cfg_err
);

  import fft_cfg_pkg::*;

  localparam int NUM_ENTRY = (LOG2_NMAX - LOG2_NMIN) / 2 + 1;
  localparam logic [3:0] DEFAULT_L = 4'(DEFAULT_LOG2N);
  localparam mode_cfg_t  DEFAULT_CFG = mode_to_cfg(DEFAULT_L);

  fe_state_t                  state_q, state_d;
  logic [3:0]                 active_q, active_d;
  logic [3:0]                 pending_q, pending_d;
  logic                       pend_flag_q, pend_flag_d;
  logic [LOG2_NMAX-1:0]       cnt_q, cnt_d;
  mode_cfg_t                  cfg_q, cfg_d;
  logic [NUM_ENTRY-1:0]       out_en_q, out_en_d;
  logic [NUM_ENTRY*WIDTH-1:0] out_re_q, out_re_d;
  logic [NUM_ENTRY*WIDTH-1:0] out_im_q, out_im_d;
  logic                       out_sop_q, out_sop_d;
  logic                       out_eop_q, out_eop_d;
  logic [LOG2_NMAX-1:0]       out_idx_q, out_idx_d;
  logic                       cfg_err_q, cfg_err_d;

  logic ready_int;
  logic accept;
  logic req_legal;
  logic req_take;
  logic active_legal_unused;
  mode_cfg_t req_cfg_unused;

  // An IDLE cycle with a request already pending goes straight to RECONFIG,
  // so it must not take a sample that would otherwise be dropped.
  assign ready_int = (state_q == RUN) || ((state_q == IDLE) && !pend_flag_q);
  assign accept    = in_valid && ready_int;
  assign req_take  = cfg_valid && req_legal;

  // Decoder for the next active size; its record is registered alongside
  // active_q so the config outputs move in the cycle after RECONFIG.
  fft_mode_decode u_active_decode (
    .log2n (active_d),
    .cfg   (cfg_d),
    .legal (active_legal_unused)
  );

  // Decoder used only to validate incoming requests.
  fft_mode_decode u_req_decode (
    .log2n (cfg_log2n),
    .cfg   (req_cfg_unused),
    .legal (req_legal)
  );

  // Frame FSM: next state, sample counter and frame markers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_sop_d = 1'b0;
    out_eop_d = 1'b0;
    out_idx_d = '0;
    case (state_q)
      IDLE: begin
        if (pend_flag_q) begin
          state_d = RECONFIG;
        end else if (accept) begin
          state_d   = RUN;
          cnt_d     = LOG2_NMAX'(1);
          out_sop_d = 1'b1;
          out_idx_d = '0;
        end
      end
      RUN: begin
        if (accept) begin
          out_idx_d = cnt_q;
          if (cnt_q == cfg_q.cnt_max) begin
            out_eop_d = 1'b1;
            cnt_d     = '0;
            state_d   = (pend_flag_q || req_take) ? RECONFIG : IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RECONFIG: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Request capture and deferred application of the pending size. A request
  // arriving during RECONFIG stays pending for the next boundary.
  always_comb begin
    pending_d   = pending_q;
    pend_flag_d = pend_flag_q;
    active_d    = active_q;
    cfg_err_d   = cfg_valid && !req_legal;
    if (state_q == RECONFIG) begin
      active_d    = pending_q;
      pend_flag_d = 1'b0;
    end
    if (req_take) begin
      pending_d   = cfg_log2n;
      pend_flag_d = 1'b1;
    end
  end

  // Per-lane steering: only the active entry lane carries the accepted sample.
  for (genvar gi = 0; gi < NUM_ENTRY; gi++) begin : g_lane
    logic lane_hit;
    assign lane_hit                      = accept && (cfg_q.entry == ENTRY_W'(gi));
    assign out_en_d[gi]                  = lane_hit;
    assign out_re_d[gi*WIDTH +: WIDTH]   = lane_hit ? in_re : '0;
    assign out_im_d[gi*WIDTH +: WIDTH]   = lane_hit ? in_im : '0;
  end

  // Control and configuration registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      active_q    <= DEFAULT_L;
      pending_q   <= DEFAULT_L;
      pend_flag_q <= 1'b0;
      cnt_q       <= '0;
      cfg_q       <= DEFAULT_CFG;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pend_flag_q <= pend_flag_d;
      cnt_q       <= cnt_d;
      cfg_q       <= cfg_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Output datapath registers (one cycle of latency).
  always_ff @(posedge clock) begin
    if (reset) begin
      out_en_q  <= '0;
      out_re_q  <= '0;
      out_im_q  <= '0;
      out_sop_q <= 1'b0;
      out_eop_q <= 1'b0;
      out_idx_q <= '0;
    end else begin
      out_en_q  <= out_en_d;
      out_re_q  <= out_re_d;
      out_im_q  <= out_im_d;
      out_sop_q <= out_sop_d;
      out_eop_q <= out_eop_d;
      out_idx_q <= out_idx_d;
    end
  end

  assign in_ready        = ready_int;
  assign out_en          = out_en_q;
  assign out_re          = out_re_q;
  assign out_im          = out_im_q;
  assign out_sop         = out_sop_q;
  assign out_eop         = out_eop_q;
  assign out_idx         = out_idx_q;
  assign cnt_max         = cfg_q.cnt_max;
  assign log2n_do        = active_q;
  assign tw_addr_shift   = cfg_q.tw_addr_shift;
  assign logn_minus_logm = cfg_q.logn_minus_logm;
  assign busy            = (state_q == RUN);
  assign cfg_err         = cfg_err_q;

endmodule

// File: tb/tb_fft_input_frontend.sv
// Directed bench for fft_input_frontend: frame marking, lane routing,
// deferred reconfiguration, illegal requests and mid-frame reset.
module tb_fft_input_frontend;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  cfg_log2n;
  logic        cfg_valid;
  logic        in_valid;
  logic [15:0] in_re;
  logic [15:0] in_im;
  logic        in_ready;
  logic [2:0]  out_en;
  logic [47:0] out_re;
  logic [47:0] out_im;
  logic        out_sop;
  logic        out_eop;
  logic [9:0]  out_idx;
  logic [9:0]  cnt_max;
  logic [3:0]  log2n_do;
  logic [2:0]  tw_addr_shift;
  logic [19:0] logn_minus_logm;
  logic        busy;
  logic        cfg_err;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  fft_input_frontend dut (
    .clock           (clock),
    .reset           (reset),
    .cfg_log2n       (cfg_log2n),
    .cfg_valid       (cfg_valid),
    .in_valid        (in_valid),
    .in_re           (in_re),
    .in_im           (in_im),
    .in_ready        (in_ready),
    .out_en          (out_en),
    .out_re          (out_re),
    .out_im          (out_im),
    .out_sop         (out_sop),
    .out_eop         (out_eop),
    .out_idx         (out_idx),
    .cnt_max         (cnt_max),
    .log2n_do        (log2n_do),
    .tw_addr_shift   (tw_addr_shift),
    .logn_minus_logm (logn_minus_logm),
    .busy            (busy),
    .cfg_err         (cfg_err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_valid = 1'b0; cfg_log2n = 4'd0;
    in_valid = 1'b0; in_re = '0; in_im = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    total++; if ({out_en, out_sop, out_eop, out_idx, busy, cfg_err} !== 16'h0) begin
      bad++; $display("FAIL reset_flags got=%h want=0", {out_en, out_sop, out_eop, out_idx, busy, cfg_err});
    end
    total++; if ({out_re, out_im} !== 96'h0) begin
      bad++; $display("FAIL reset_data got=%h want=0", {out_re, out_im});
    end
    total++; if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    total++; if (cnt_max !== 10'd255 || tw_addr_shift !== 3'd2 || log2n_do !== 4'd8) begin
      bad++; $display("FAIL reset_cfg got=%0d/%0d/%0d want=255/2/8", cnt_max, tw_addr_shift, log2n_do);
    end
    total++; if (logn_minus_logm !== 20'h64200) begin
      bad++; $display("FAIL reset_lml got=%h want=64200", logn_minus_logm);
    end
    $display("reset: checked");
  endtask

  task automatic test_frame256();
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_re = 16'(i); in_im = 16'(16'hA000 + i);
      total++; if (in_ready !== 1'b1) begin
        bad++; $display("FAIL f256_ready idx=%0d got=%b want=1", i, in_ready);
      end
      if (i == 0) begin
        total++; if (out_en !== 3'b000) begin
          bad++; $display("FAIL f256_latency got=%b want=000", out_en);
        end
      end
      tick();
      total++; if (out_en !== 3'b010 || out_idx !== 10'(i)) begin
        bad++; $display("FAIL f256_lane_idx i=%0d got=%b/%0d want=010/%0d", i, out_en, out_idx, i);
      end
      total++; if (out_re !== {16'h0, 16'(i), 16'h0} || out_im !== {16'h0, 16'(16'hA000 + i), 16'h0}) begin
        bad++; $display("FAIL f256_data i=%0d got=%h/%h want lane1=%h", i, out_re, out_im, 16'(i));
      end
      total++; if (out_sop !== (i == 0) || out_eop !== (i == 255)) begin
        bad++; $display("FAIL f256_marks i=%0d got=%b%b want=%b%b", i, out_sop, out_eop, i == 0, i == 255);
      end
      total++; if (busy !== (i != 255)) begin
        bad++; $display("FAIL f256_busy i=%0d got=%b want=%b", i, busy, i != 255);
      end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_en !== 3'b000 || out_re !== 48'h0 || busy !== 1'b0) begin
      bad++; $display("FAIL f256_after got=%b/%h/%b want=000/0/0", out_en, out_re, busy);
    end
    $display("frame256: 256 samples");
  endtask

  task automatic test_midframe_cfg();
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_re = 16'(i + 7); in_im = 16'(i);
      cfg_valid = (i == 100); cfg_log2n = 4'd6;
      tick();
      total++; if (out_en !== 3'b010 || out_idx !== 10'(i) || out_eop !== (i == 255)) begin
        bad++; $display("FAIL mid_frame i=%0d got=%b/%0d/%b want=010/%0d/%b", i, out_en, out_idx, out_eop, i, i == 255);
      end
      if (i == 200) begin
        total++; if (cnt_max !== 10'd255 || log2n_do !== 4'd8) begin
          bad++; $display("FAIL mid_cfg_held got=%0d/%0d want=255/8", cnt_max, log2n_do);
        end
      end
    end
    cfg_valid = 1'b0; in_re = 16'h1234;
    total++; if (in_ready !== 1'b0) begin
      bad++; $display("FAIL mid_bubble got=%b want=0", in_ready);
    end
    tick();
    total++; if (in_ready !== 1'b1 || out_en !== 3'b000) begin
      bad++; $display("FAIL mid_after_bubble got=%b/%b want=1/000", in_ready, out_en);
    end
    total++; if (log2n_do !== 4'd6 || cnt_max !== 10'd63 || tw_addr_shift !== 3'd4) begin
      bad++; $display("FAIL mid_newcfg got=%0d/%0d/%0d want=6/63/4", log2n_do, cnt_max, tw_addr_shift);
    end
    total++; if (logn_minus_logm !== 20'h42000) begin
      bad++; $display("FAIL mid_lml got=%h want=42000", logn_minus_logm);
    end
    in_valid = 1'b0;
    $display("midframe_cfg: L=6 deferred to boundary");
  endtask

  task automatic test_eop_cfg();
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1; in_re = 16'(3 * i); in_im = 16'(16'hFFFF - i);
      cfg_valid = (i == 63); cfg_log2n = 4'd10;
      tick();
      total++; if (out_en !== 3'b100 || out_re !== {16'(3 * i), 32'h0} || out_im !== {16'(16'hFFFF - i), 32'h0}) begin
        bad++; $display("FAIL f64_lane i=%0d got=%b/%h want=100/%h", i, out_en, out_re, 16'(3 * i));
      end
      total++; if (out_sop !== (i == 0) || out_eop !== (i == 63) || out_idx !== 10'(i)) begin
        bad++; $display("FAIL f64_marks i=%0d got=%b%b/%0d", i, out_sop, out_eop, out_idx);
      end
    end
    cfg_valid = 1'b0; in_valid = 1'b0;
    total++; if (in_ready !== 1'b0 || busy !== 1'b0 || log2n_do !== 4'd6) begin
      bad++; $display("FAIL eop_reconfig got=%b/%b/%0d want=0/0/6", in_ready, busy, log2n_do);
    end
    tick();
    total++; if (log2n_do !== 4'd10 || cnt_max !== 10'd1023 || tw_addr_shift !== 3'd0) begin
      bad++; $display("FAIL eop_newcfg got=%0d/%0d/%0d want=10/1023/0", log2n_do, cnt_max, tw_addr_shift);
    end
    total++; if (logn_minus_logm !== 20'h86420) begin
      bad++; $display("FAIL eop_lml got=%h want=86420", logn_minus_logm);
    end
    for (int i = 0; i < 1024; i++) begin
      in_valid = 1'b1; in_re = 16'(i ^ 16'h5A5A); in_im = 16'(i);
      tick();
      total++; if (out_en !== 3'b001 || out_re !== {32'h0, 16'(i ^ 16'h5A5A)} || out_eop !== (i == 1023)) begin
        bad++; $display("FAIL f1024 i=%0d got=%b/%h/%b", i, out_en, out_re, out_eop);
      end
    end
    in_valid = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL f1024_end got=%b/%b want=0/1", busy, in_ready);
    end
    $display("eop_cfg: L=10 applied, 1024 frame on lane 0");
  endtask

  task automatic test_cfg_err();
    cfg_valid = 1'b1; cfg_log2n = 4'd11;
    tick();
    total++; if (cfg_err !== 1'b1 || log2n_do !== 4'd10) begin
      bad++; $display("FAIL err11 got=%b/%0d want=1/10", cfg_err, log2n_do);
    end
    cfg_valid = 1'b0;
    tick();
    total++; if (cfg_err !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL err11_pulse got=%b/%b want=0/1", cfg_err, in_ready);
    end
    cfg_valid = 1'b1; cfg_log2n = 4'd4;
    tick();
    total++; if (cfg_err !== 1'b1) begin
      bad++; $display("FAIL err4 got=%b want=1", cfg_err);
    end
    cfg_valid = 1'b0;
    tick(); tick();
    total++; if (cfg_err !== 1'b0 || log2n_do !== 4'd10 || in_ready !== 1'b1) begin
      bad++; $display("FAIL err4_after got=%b/%0d/%b want=0/10/1", cfg_err, log2n_do, in_ready);
    end
    cfg_valid = 1'b1; cfg_log2n = 4'd5;
    tick();
    cfg_log2n = 4'd11;
    tick();
    total++; if (cfg_err !== 1'b1 || log2n_do !== 4'd10) begin
      bad++; $display("FAIL err_pend got=%b/%0d want=1/10", cfg_err, log2n_do);
    end
    cfg_valid = 1'b0;
    tick();
    total++; if (log2n_do !== 4'd5 || cnt_max !== 10'd31 || tw_addr_shift !== 3'd5 || logn_minus_logm !== 20'h02000) begin
      bad++; $display("FAIL err_pend_kept got=%0d/%0d/%0d/%h want=5/31/5/02000", log2n_do, cnt_max, tw_addr_shift, logn_minus_logm);
    end
    $display("cfg_err: L=11 and L=4 rejected");
  endtask

  task automatic test_back_to_back();
    cfg_valid = 1'b1; cfg_log2n = 4'd9;
    tick();
    cfg_log2n = 4'd7;
    tick();
    total++; if (log2n_do !== 4'd5) begin
      bad++; $display("FAIL b2b_hold got=%0d want=5", log2n_do);
    end
    cfg_valid = 1'b0;
    tick();
    total++; if (log2n_do !== 4'd7 || cnt_max !== 10'd127 || tw_addr_shift !== 3'd3 || logn_minus_logm !== 20'h04200) begin
      bad++; $display("FAIL b2b_cfg got=%0d/%0d/%0d/%h want=7/127/3/04200", log2n_do, cnt_max, tw_addr_shift, logn_minus_logm);
    end
    tick();
    total++; if (log2n_do !== 4'd7 || in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_stable got=%0d/%b want=7/1", log2n_do, in_ready);
    end
    for (int i = 0; i < 128; i++) begin
      in_valid = 1'b1; in_re = 16'(i); in_im = 16'(i);
      tick();
      total++; if (out_en !== 3'b010 || out_sop !== (i == 0) || out_eop !== (i == 127)) begin
        bad++; $display("FAIL f128 i=%0d got=%b/%b%b", i, out_en, out_sop, out_eop);
      end
    end
    in_valid = 1'b0;
    tick();
    $display("back_to_back: only L=7 applied");
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_re = 16'(i); in_im = 16'(i);
      tick();
    end
    total++; if (out_idx !== 10'd39 || busy !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre got=%0d/%b want=39/1", out_idx, busy);
    end
    in_re = 16'd40; reset = 1'b1;
    tick();
    total++; if ({out_en, out_sop, out_eop, out_idx, busy, cfg_err} !== 16'h0 || {out_re, out_im} !== 96'h0) begin
      bad++; $display("FAIL rstmid_out got=%h want=0", {out_en, out_sop, out_eop, out_idx, busy, cfg_err});
    end
    total++; if (in_ready !== 1'b1 || log2n_do !== 4'd8 || cnt_max !== 10'd255 || tw_addr_shift !== 3'd2 || logn_minus_logm !== 20'h64200) begin
      bad++; $display("FAIL rstmid_cfg got=%b/%0d/%0d/%0d/%h want=1/8/255/2/64200", in_ready, log2n_do, cnt_max, tw_addr_shift, logn_minus_logm);
    end
    reset = 1'b0; in_re = 16'h0777;
    tick();
    total++; if (out_sop !== 1'b1 || out_idx !== 10'd0 || out_en !== 3'b010 || out_re !== {16'h0, 16'h0777, 16'h0}) begin
      bad++; $display("FAIL rstmid_sop got=%b/%0d/%b/%h want=1/0/010/0777 in lane1", out_sop, out_idx, out_en, out_re);
    end
    in_valid = 1'b0;
    $display("reset_midframe: restart at sop");
  endtask

  initial begin
    test_reset();
    test_frame256();
    test_midframe_cfg();
    test_eop_cfg();
    test_cfg_err();
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
